// File: rtl/cpu_alu_seq.sv
// 8008 ALU-group sequencer: fetches A and the source operand, drives the external
// combinational ALU for one cycle, writes A back and owns the C/Z/S/P flags.
//   state | meaning
//   IDLE  | ready for the next opcode
//   RDA   | RF read of A issued
//   CPA   | A captured; issue source read, go to memory, or take immediate
//   LDS   | register operand captured
//   MEM   | memory read outstanding until MEM_ACK_I
//   EXE   | ALU driven, A written back, flags latched
module cpu_alu_seq (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       INST_VLD_I,
  output logic       INST_RDY_O,
  input  logic [7:0] INST_I,
  input  logic [7:0] IMM_I,
  output logic       ILL_O,
  output logic       DONE_O,
  output logic       RF_RD_O,
  output logic [2:0] RF_ADDR_O,
  input  logic [7:0] RF_DATA_I,
  output logic       RF_WE_O,
  output logic [7:0] RF_WDATA_O,
  output logic       MEM_REQ_O,
  input  logic       MEM_ACK_I,
  input  logic [7:0] MEM_DATA_I,
  output logic [7:0] ALU_X_O,
  output logic [7:0] ALU_Y_O,
  output logic       ALU_C_O,
  output logic [2:0] ALU_OP_O,
  input  logic [7:0] ALU_E_I,
  input  logic       ALU_C_I,
  output logic       FLAG_C_O,
  output logic       FLAG_Z_O,
  output logic       FLAG_S_O,
  output logic       FLAG_P_O
);

  typedef enum logic [2:0] {S_IDLE, S_RDA, S_CPA, S_LDS, S_MEM, S_EXE} state_t;

  localparam logic [2:0] OP_AC = 3'd1;
  localparam logic [2:0] OP_SU = 3'd2;
  localparam logic [2:0] OP_SB = 3'd3;
  localparam logic [2:0] OP_ND = 3'd4;
  localparam logic [2:0] OP_XR = 3'd5;
  localparam logic [2:0] OP_OR = 3'd6;
  localparam logic [2:0] OP_CP = 3'd7;
  localparam logic [2:0] SRC_M = 3'd7;

  state_t     state_q, state_d;
  logic [7:0] inst_q, inst_d;
  logic [7:0] imm_q, imm_d;
  logic [7:0] a_q, a_d;
  logic [7:0] opnd_q, opnd_d;
  logic       ill_q, ill_d;
  logic       flag_c_q, flag_c_d;
  logic       flag_z_q, flag_z_d;
  logic       flag_s_q, flag_s_d;
  logic       flag_p_q, flag_p_d;

  logic [2:0] ppp;
  logic [2:0] sss;
  logic       is_imm;
  logic       new_alu;

  assign ppp     = inst_q[5:3];
  assign sss     = inst_q[2:0];
  assign is_imm  = (inst_q[7:6] == 2'b00);
  assign new_alu = (INST_I[7:6] == 2'b10) ||
                   ((INST_I[7:6] == 2'b00) && (INST_I[2:0] == 3'b100));

  always_comb begin
    state_d    = state_q;
    inst_d     = inst_q;
    imm_d      = imm_q;
    a_d        = a_q;
    opnd_d     = opnd_q;
    ill_d      = 1'b0;
    flag_c_d   = flag_c_q;
    flag_z_d   = flag_z_q;
    flag_s_d   = flag_s_q;
    flag_p_d   = flag_p_q;
    INST_RDY_O = 1'b0;
    DONE_O     = 1'b0;
    RF_RD_O    = 1'b0;
    RF_ADDR_O  = 3'd0;
    RF_WE_O    = 1'b0;
    RF_WDATA_O = 8'd0;
    MEM_REQ_O  = 1'b0;
    ALU_X_O    = 8'd0;
    ALU_Y_O    = 8'd0;
    ALU_C_O    = 1'b0;
    ALU_OP_O   = 3'd0;

    case (state_q)
      S_IDLE: begin
        INST_RDY_O = 1'b1;
        if (INST_VLD_I) begin
          inst_d = INST_I;
          imm_d  = IMM_I;
          if (new_alu) state_d = S_RDA;
          else         ill_d   = 1'b1;
        end
      end
      S_RDA: begin
        RF_RD_O = 1'b1;
        state_d = S_CPA;
      end
      S_CPA: begin
        a_d = RF_DATA_I;
        if (is_imm) begin
          opnd_d  = imm_q;
          state_d = S_EXE;
        end else if (sss == SRC_M) begin
          state_d = S_MEM;
        end else begin
          RF_RD_O   = 1'b1;
          RF_ADDR_O = sss;
          state_d   = S_LDS;
        end
      end
      S_LDS: begin
        opnd_d  = RF_DATA_I;
        state_d = S_EXE;
      end
      S_MEM: begin
        MEM_REQ_O = 1'b1;
        if (MEM_ACK_I) begin
          opnd_d  = MEM_DATA_I;
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        ALU_X_O = a_q;
        ALU_Y_O = opnd_q;
        // The ALU only sees add-with-carry and subtract-with-borrow; the plain
        // forms and compare force carry-in to 0.
        case (ppp)
          3'd0:    ALU_OP_O = OP_AC;
          OP_AC:   begin ALU_OP_O = OP_AC; ALU_C_O = flag_c_q; end
          OP_SU:   ALU_OP_O = OP_SB;
          OP_SB:   begin ALU_OP_O = OP_SB; ALU_C_O = flag_c_q; end
          OP_CP:   ALU_OP_O = OP_SB;
          default: ALU_OP_O = ppp;
        endcase
        if (ppp != OP_CP) begin
          RF_WE_O    = 1'b1;
          RF_WDATA_O = ALU_E_I;
        end
        flag_z_d = ~|ALU_E_I;
        flag_s_d = ALU_E_I[7];
        flag_p_d = ~^ALU_E_I;
        flag_c_d = (ppp == OP_ND || ppp == OP_XR || ppp == OP_OR) ? 1'b0 : ALU_C_I;
        DONE_O   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q  <= S_IDLE;
      inst_q   <= 8'd0;
      imm_q    <= 8'd0;
      a_q      <= 8'd0;
      opnd_q   <= 8'd0;
      ill_q    <= 1'b0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_s_q <= 1'b0;
      flag_p_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      inst_q   <= inst_d;
      imm_q    <= imm_d;
      a_q      <= a_d;
      opnd_q   <= opnd_d;
      ill_q    <= ill_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
      flag_s_q <= flag_s_d;
      flag_p_q <= flag_p_d;
    end
  end

  assign ILL_O    = ill_q;
  assign FLAG_C_O = flag_c_q;
  assign FLAG_Z_O = flag_z_q;
  assign FLAG_S_O = flag_s_q;
  assign FLAG_P_O = flag_p_q;

endmodule

// File: tb/tb_cpu_alu_seq.sv
// Bench for cpu_alu_seq: register file, memory and ALU models around the DUT,
// directed cases followed by random instructions against an arithmetic reference.
module tb_cpu_alu_seq;

  logic       clk = 1'b0;
  logic       rst, vld, rdy, ill, done;
  logic [7:0] inst, imm;
  logic       rf_rd, rf_we;
  logic [2:0] rf_addr;
  logic [7:0] rf_data, rf_wdata;
  logic       mem_req, mem_ack;
  logic [7:0] mem_data;
  logic [7:0] alu_x, alu_y, alu_e;
  logic       alu_cin, alu_cout;
  logic [2:0] alu_op;
  logic       fc, fz, fs, fp;

  always #5 clk = ~clk;

  cpu_alu_seq dut (
    .CLK_I(clk), .RST_I(rst), .INST_VLD_I(vld), .INST_RDY_O(rdy),
    .INST_I(inst), .IMM_I(imm), .ILL_O(ill), .DONE_O(done),
    .RF_RD_O(rf_rd), .RF_ADDR_O(rf_addr), .RF_DATA_I(rf_data),
    .RF_WE_O(rf_we), .RF_WDATA_O(rf_wdata),
    .MEM_REQ_O(mem_req), .MEM_ACK_I(mem_ack), .MEM_DATA_I(mem_data),
    .ALU_X_O(alu_x), .ALU_Y_O(alu_y), .ALU_C_O(alu_cin), .ALU_OP_O(alu_op),
    .ALU_E_I(alu_e), .ALU_C_I(alu_cout),
    .FLAG_C_O(fc), .FLAG_Z_O(fz), .FLAG_S_O(fs), .FLAG_P_O(fp)
  );

  // ALU model: 8008 op encoding, carry/borrow out on bit 8
  logic [8:0] alu_t;
  always_comb begin
    alu_t = 9'd0;
    case (alu_op)
      3'd0: alu_t = {1'b0, alu_x} + {1'b0, alu_y};
      3'd1: alu_t = {1'b0, alu_x} + {1'b0, alu_y} + {8'd0, alu_cin};
      3'd2: alu_t = {1'b0, alu_x} - {1'b0, alu_y};
      3'd3: alu_t = {1'b0, alu_x} - {1'b0, alu_y} - {8'd0, alu_cin};
      3'd4: alu_t = {1'b0, alu_x & alu_y};
      3'd5: alu_t = {1'b0, alu_x ^ alu_y};
      3'd6: alu_t = {1'b0, alu_x | alu_y};
      default: alu_t = {1'b0, alu_x} - {1'b0, alu_y};
    endcase
  end
  assign alu_e    = alu_t[7:0];
  assign alu_cout = alu_t[8];

  // register file with one-cycle read latency and a bench load port
  logic [7:0] rf [8];
  logic       ld_en = 1'b0;
  logic [2:0] ld_idx = 3'd0;
  logic [7:0] ld_val = 8'd0;
  always @(posedge clk) begin
    if (ld_en)      rf[ld_idx] <= ld_val;
    else if (rf_we) rf[0]      <= rf_wdata;
    if (rf_rd)      rf_data    <= rf[rf_addr];
  end

  // memory: ack after mem_wait cycles of REQ, plus optional stray acks
  int   mem_wait = 0;
  int   req_seen = 0;
  logic stray_bit = 1'b0;
  always @(posedge clk) req_seen <= mem_req ? req_seen + 1 : 0;
  assign mem_ack = (mem_req && (req_seen == mem_wait)) || stray_bit;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] ref_rf [8];
  bit ref_c, ref_z, ref_s, ref_p;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_reg(input logic [2:0] idx, input logic [7:0] val);
    ld_en = 1'b1; ld_idx = idx; ld_val = val;
    ref_rf[idx] = val;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic run_inst(input logic [7:0] op_byte, input logic [7:0] imm_byte,
                          input logic [7:0] mbyte, input int mwait, input bit noise);
    bit legal, is_imm, is_m;
    logic [2:0] ppp, sss, eop;
    logic [7:0] res;
    bit nc, ec;
    int a, opv, r, lat, cyc, we_cnt, req_cnt;

    legal  = (op_byte[7:6] == 2'b10) || (op_byte[7:6] == 2'b00 && op_byte[2:0] == 3'b100);
    is_imm = (op_byte[7:6] == 2'b00);
    ppp    = op_byte[5:3];
    sss    = op_byte[2:0];
    is_m   = !is_imm && (sss == 3'd7);

    a   = int'(ref_rf[0]);
    opv = is_imm ? int'(imm_byte) : is_m ? int'(mbyte) : int'(ref_rf[sss]);
    case (ppp)
      3'd0: r = a + opv;
      3'd1: r = a + opv + int'(ref_c);
      3'd2: r = a - opv;
      3'd3: r = a - opv - int'(ref_c);
      3'd4: r = a & opv;
      3'd5: r = a ^ opv;
      3'd6: r = a | opv;
      default: r = a - opv;
    endcase
    res = r[7:0];
    if (ppp <= 3'd1)                               nc = (r > 255);
    else if (ppp == 3'd2 || ppp == 3'd3 || ppp == 3'd7) nc = (r < 0);
    else                                           nc = 1'b0;
    case (ppp)
      3'd0, 3'd1: eop = 3'd1;
      3'd2, 3'd3, 3'd7: eop = 3'd3;
      default: eop = ppp;
    endcase
    ec  = (ppp == 3'd1 || ppp == 3'd3) ? ref_c : 1'b0;
    lat = is_imm ? 3 : is_m ? 4 + mwait : 4;

    mem_data = mbyte; mem_wait = mwait;
    vld = 1'b1; inst = op_byte; imm = imm_byte;
    chk("rdy_before_accept", 32'(rdy), 32'd1);
    @(posedge clk); #1;
    vld = 1'b0; inst = 8'($urandom); imm = 8'($urandom);

    if (!legal) begin
      chk("ill_pulse", 32'(ill), 32'd1);
      chk("ill_rdy", 32'(rdy), 32'd1);
      chk("ill_no_rd", 32'(rf_rd), 32'd0);
      chk("ill_no_req", 32'(mem_req), 32'd0);
      @(posedge clk); #1;
      chk("ill_clear", 32'(ill), 32'd0);
      chk("ill_no_rd2", 32'(rf_rd), 32'd0);
      chk("ill_no_req2", 32'(mem_req), 32'd0);
      chk("ill_rdy2", 32'(rdy), 32'd1);
      return;
    end

    cyc = 1; we_cnt = 0; req_cnt = 0;
    while (!done && cyc < 40) begin
      chk("alu_idle", {alu_x, alu_y, 5'd0, alu_cin, alu_op}, 32'd0);
      if (rf_we)   we_cnt++;
      if (mem_req) req_cnt++;
      stray_bit = (noise && !is_m) ? 1'($urandom_range(0, 1)) : 1'b0;
      vld  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      inst = 8'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    stray_bit = 1'b0;
    vld = 1'b0;
    chk("latency", 32'(cyc), 32'(lat));
    chk("exe_x", 32'(alu_x), 32'(a));
    chk("exe_y", 32'(alu_y), 32'(opv));
    chk("exe_op", 32'(alu_op), 32'(eop));
    chk("exe_cin", 32'(alu_cin), 32'(ec));
    chk("exe_we", 32'(rf_we), 32'(ppp != 3'd7));
    if (ppp != 3'd7) chk("exe_wdata", 32'(rf_wdata), 32'(res));

    if (ppp != 3'd7) ref_rf[0] = res;
    ref_c = nc; ref_z = (res == 8'd0); ref_s = res[7]; ref_p = ($countones(res) % 2 == 0);

    @(posedge clk); #1;
    chk("reg_a", 32'(rf[0]), 32'(ref_rf[0]));
    chk("flag_c", 32'(fc), 32'(ref_c));
    chk("flag_z", 32'(fz), 32'(ref_z));
    chk("flag_s", 32'(fs), 32'(ref_s));
    chk("flag_p", 32'(fp), 32'(ref_p));
    chk("done_pulse", 32'(done), 32'd0);
    chk("rdy_after", 32'(rdy), 32'd1);
    chk("req_after", 32'(mem_req), 32'd0);
    chk("we_outside_exe", 32'(we_cnt), 32'd0);
    chk("req_cycles", 32'(req_cnt), is_m ? 32'(mwait + 1) : 32'd0);
  endtask

  int         k, kind, cyc;
  logic [2:0] rp;
  logic [7:0] rinst;

  initial begin
    rst = 1'b1; vld = 1'b0; inst = 8'd0; imm = 8'd0; mem_data = 8'd0;
    ref_c = 0; ref_z = 0; ref_s = 0; ref_p = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_rdy", 32'(rdy), 32'd1);
    chk("rst_outs", {ill, done, rf_rd, rf_we, mem_req, alu_cin, fc, fz, fs, fp}, 32'd0);
    chk("rst_alu", {alu_x, alu_y, alu_op}, 32'd0);

    for (int i = 0; i < 7; i++) set_reg(3'(i), 8'($urandom));

    set_reg(3'd0, 8'h3C); set_reg(3'd1, 8'h05);
    run_inst(8'h81, 8'h00, 8'h00, 0, 1'b0);          // ADD B
    chk("add_b_a", 32'(rf[0]), 32'h41);
    set_reg(3'd0, 8'hFF);
    run_inst(8'h04, 8'h01, 8'h00, 0, 1'b0);          // ADI 01
    chk("adi_c", 32'(fc), 32'd1);
    set_reg(3'd0, 8'h10);
    run_inst(8'h1C, 8'h20, 8'h00, 0, 1'b0);          // SBI 20 with C=1
    chk("sbi_a", 32'(rf[0]), 32'hEF);
    run_inst(8'h3C, 8'hEF, 8'h00, 0, 1'b0);          // CPI EF
    chk("cpi_z", {30'd0, fz, fc}, 32'b10);
    set_reg(3'd0, 8'h0F);
    run_inst(8'hA7, 8'h00, 8'hF3, 5, 1'b0);          // ANA M, ack delayed
    chk("ana_m_a", 32'(rf[0]), 32'h03);
    run_inst(8'h06, 8'h55, 8'h00, 0, 1'b0);          // MVI -> illegal

    mem_wait = 20; mem_data = 8'h5A;
    vld = 1'b1; inst = 8'hA7;
    @(posedge clk); #1;
    vld = 1'b0;
    cyc = 0;
    while (!mem_req && cyc < 10) begin @(posedge clk); #1; cyc++; end
    chk("rst_req_seen", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ref_c = 0; ref_z = 0; ref_s = 0; ref_p = 0;
    chk("rst_req_drop", 32'(mem_req), 32'd0);
    chk("rst_flags", {fc, fz, fs, fp}, 32'd0);
    chk("rst_idle_rdy", 32'(rdy), 32'd1);
    @(posedge clk); #1;
    chk("rst_req_stays", 32'(mem_req), 32'd0);
    chk("rst_a_kept", 32'(rf[0]), 32'(ref_rf[0]));

    for (k = 0; k < 80; k++) begin
      kind = int'($urandom_range(0, 9));
      rp   = 3'($urandom_range(0, 7));
      if (kind == 0) set_reg(3'($urandom_range(0, 6)), 8'($urandom));
      if (kind <= 4) begin
        rinst = {2'b10, rp, 3'($urandom_range(0, 6))};
        run_inst(rinst, 8'($urandom), 8'($urandom), 0, 1'b1);
      end else if (kind <= 6) begin
        rinst = {2'b10, rp, 3'b111};
        run_inst(rinst, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'b1);
      end else if (kind <= 8) begin
        rinst = {2'b00, rp, 3'b100};
        run_inst(rinst, 8'($urandom), 8'($urandom), 0, 1'b1);
      end else begin
        rinst = {2'b01, 6'($urandom)};
        run_inst(rinst, 8'($urandom), 8'($urandom), 0, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
